// File: rtl/mesh_injector_if.sv
// Core-to-injector event channel and injector-to-node packet channel of the NoC mesh.
// A beat moves on a rising edge where valid and ready are both high. Once valid is raised, the sender holds it and its data stable until that edge.
interface mesh_injector_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_dst_x;
  logic [3:0]  ev_dst_y;
  logic [15:0] ev_payload;
  logic [31:0] dout;
  logic        vout;
  logic        rin;

  // master: the injector itself; slave: the local core plus the node input port
  modport master (
    input  ev_valid, ev_dst_x, ev_dst_y, ev_payload, rin,
    output ev_ready, dout, vout
  );
  modport slave (
    output ev_valid, ev_dst_x, ev_dst_y, ev_payload, rin,
    input  ev_ready, dout, vout
  );
endinterface

// File: rtl/mesh_injector.sv
// Injection interface for the NoC mesh: queues spike events as 32-bit packets in a FIFO
// and presents them to a node input port through one output register; unroutable events are discarded.
module mesh_injector #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SRC_X      = 0,
    parameter int SRC_Y      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    mesh_injector_if.master                      bus,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic [15:0]                          tx_count,
    output logic                                 err_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam logic [4:0] COLS_L = 5'(COLS);
    localparam logic [4:0] ROWS_L = 5'(ROWS);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          accept;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          transfer;
    logic [31:0]   pkt;

    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign accept   = bus.ev_valid & bus.ev_ready;
    assign in_range = ({1'b0, bus.ev_dst_x} < COLS_L) && ({1'b0, bus.ev_dst_y} < ROWS_L);
    assign push     = accept & in_range;
    assign transfer = bus.vout & bus.rin;
    // Refill the output register whenever it is empty or being drained this edge.
    assign pop      = ~empty & (~bus.vout | transfer);
    assign pkt      = {bus.ev_dst_x, bus.ev_dst_y, 4'(SRC_X), 4'(SRC_Y), bus.ev_payload};

    // Readiness depends only on level, so a simultaneous pop never lets a full FIFO take a push.
    assign bus.ev_ready = rst & ~full;
    assign busy         = ~empty | bus.vout;
    assign fifo_level   = level;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pkt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.vout <= 1'b0;
            bus.dout <= '0;
        end else if (pop) begin
            bus.vout <= 1'b1;
            bus.dout <= mem[rd_ptr];
        end else if (transfer) begin
            bus.vout <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count <= '0;
            err_drop <= 1'b0;
        end else begin
            if (transfer) tx_count <= tx_count + 16'd1;
            if (accept && !in_range) err_drop <= 1'b1;
        end
    end

endmodule
